// File: rtl/sys_exec_sequencer.sv
// sys_exec_sequencer
// Execution sequencer for the systolic array datapath. A start pulse from the
// controller launches one operation: rows are read from the unified buffer one
// per non-held cycle (FEED), each read launches a valid token through a
// PIPE_LAT-deep shift register, and each token leaving the register becomes an
// accumulator write. After the last write the block pulses sys_done (DONE) and
// returns to IDLE.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   sys_start, sys_rows   issue pulse and row count (sampled together)
//   ub_base, acc_base     first UB read / accumulator write address
//   hold                  backpressure; freezes FEED/DRAIN and gates strobes
//   sys_busy, sys_done    operation in progress / one-cycle completion pulse
//   ub_rd_en, ub_rd_addr  unified-buffer read strobe and address
//   arr_en                array compute enable
//   acc_wr_en, acc_wr_addr accumulator write strobe and address
//   sys_err               sticky: start seen while not IDLE
//   perf_cycles           busy cycles of the last operation
//
// Optional feature: define SYS_SEQ_PERF_EN to build the perf_cycles counter;
// otherwise perf_cycles is tied to zero.
module sys_exec_sequencer #(
  parameter int N        = 4,
  parameter int PIPE_LAT = 2*N,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sys_start,
  input  logic [7:0]    sys_rows,
  input  logic [AW-1:0] ub_base,
  input  logic [AW-1:0] acc_base,
  input  logic          hold,
  output logic          sys_busy,
  output logic          sys_done,
  output logic          ub_rd_en,
  output logic [AW-1:0] ub_rd_addr,
  output logic          arr_en,
  output logic          acc_wr_en,
  output logic [AW-1:0] acc_wr_addr,
  output logic          sys_err,
  output logic [15:0]   perf_cycles
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [7:0]            rows_q, rd_cnt, wr_cnt;
  logic [AW-1:0]         ub_q, acc_q;
  logic [PIPE_LAT-1:0]   vld_pipe;
  logic                  busy, adv, rd_fire, wr_fire, start_ok;

  assign busy     = (state == FEED) || (state == DRAIN);
  assign adv      = busy && !hold;
  assign rd_fire  = (state == FEED) && !hold;
  // Tokens can exit while still feeding when rows > PIPE_LAT.
  assign wr_fire  = adv && vld_pipe[PIPE_LAT-1];
  assign start_ok = sys_start && (state == IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (sys_start) state_nxt = (sys_rows == 8'd0) ? DONE : FEED;
      FEED:  if (rd_fire && rd_cnt == rows_q - 8'd1) state_nxt = DRAIN;
      DRAIN: if (wr_fire && wr_cnt == rows_q - 8'd1) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rows_q   <= '0;
      ub_q     <= '0;
      acc_q    <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      vld_pipe <= '0;
      sys_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        rows_q   <= sys_rows;
        ub_q     <= ub_base;
        acc_q    <= acc_base;
        rd_cnt   <= '0;
        wr_cnt   <= '0;
        vld_pipe <= '0;
      end else if (adv) begin
        // Held cycles skip this branch, so the whole pipeline stalls as a unit.
        vld_pipe <= {vld_pipe[PIPE_LAT-2:0], rd_fire};
        if (rd_fire) rd_cnt <= rd_cnt + 8'd1;
        if (wr_fire) wr_cnt <= wr_cnt + 8'd1;
      end
      if (sys_start && state != IDLE) sys_err <= 1'b1;
    end
  end

  assign sys_busy    = busy;
  assign sys_done    = (state == DONE);
  assign arr_en      = adv;
  assign ub_rd_en    = rd_fire;
  assign acc_wr_en   = wr_fire;
  assign ub_rd_addr  = ub_q + AW'(rd_cnt);
  assign acc_wr_addr = acc_q + AW'(wr_cnt);

`ifdef SYS_SEQ_PERF_EN
  logic [15:0] perf_q;
  always_ff @(posedge clk) begin
    if (!rst_n)                         perf_q <= '0;
    else if (start_ok)                  perf_q <= '0;
    else if (busy && perf_q != 16'hFFFF) perf_q <= perf_q + 16'd1;
  end
  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_sys_exec_sequencer.sv
// Bench for sys_exec_sequencer: a constant table for the basic 4-row run,
// directed multi-cycle sequences, then random traffic, all compared each cycle
// against a schedule model (counts non-held busy cycles and derives strobes
// and addresses arithmetically from that count).
module tb_sys_exec_sequencer;
  localparam int N = 4;
  localparam int P = 2*N;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, sys_start = 1'b0, hold = 1'b0;
  logic [7:0] sys_rows = '0, ub_base = '0, acc_base = '0;
  logic       sys_busy, sys_done, ub_rd_en, arr_en, acc_wr_en, sys_err;
  logic [7:0] ub_rd_addr, acc_wr_addr;
  logic [15:0] perf_cycles;

  always #5 clk = ~clk;

  sys_exec_sequencer #(.N(N), .PIPE_LAT(P), .AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .sys_start(sys_start), .sys_rows(sys_rows),
    .ub_base(ub_base), .acc_base(acc_base), .hold(hold),
    .sys_busy(sys_busy), .sys_done(sys_done), .ub_rd_en(ub_rd_en),
    .ub_rd_addr(ub_rd_addr), .arr_en(arr_en), .acc_wr_en(acc_wr_en),
    .acc_wr_addr(acc_wr_addr), .sys_err(sys_err), .perf_cycles(perf_cycles)
  );

  typedef struct packed {
    logic busy, done, rd, arr, wr, err;
    logic [7:0] rd_addr, wr_addr;
    logic [15:0] perf;
  } out_t;

  typedef struct {
    logic start; logic [7:0] rows, ub, acc; logic hold;
    out_t exp;
  } vec_t;

  int nvec = 0, nerr = 0, cyc = 0;

  // schedule model
  bit m_busy, m_done, m_err;
  int m_a, m_rows, m_perf;
  logic [7:0] m_ub, m_acc;

  function automatic logic [15:0] perf_val(int v);
`ifdef SYS_SEQ_PERF_EN
    return v[15:0];
`else
    return 16'd0;
`endif
  endfunction

  function automatic out_t model_out(logic h);
    out_t o;
    int w;
    o = '0;
    o.busy = m_busy;
    o.done = m_done;
    o.err  = m_err;
    o.perf = perf_val(m_perf);
    if (m_busy && !h) begin
      o.arr = 1'b1;
      if (m_a < m_rows) begin
        o.rd = 1'b1;
        o.rd_addr = 8'((int'(m_ub) + m_a) % 256);
      end
      w = m_a - P;
      if (w >= 0 && w < m_rows) begin
        o.wr = 1'b1;
        o.wr_addr = 8'((int'(m_acc) + w) % 256);
      end
    end
    return o;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_err = 0; m_a = 0; m_rows = 0; m_perf = 0;
    m_ub = '0; m_acc = '0;
  endtask

  // Advance the model across one clock edge.
  task automatic model_step(logic rst, logic st, logic [7:0] rows,
                            logic [7:0] ub, logic [7:0] acc, logic h);
    bit nd;
    if (!rst) begin
      model_reset();
      return;
    end
    nd = 0;
    if (st && (m_busy || m_done)) m_err = 1;
    if (m_busy) begin
      if (m_perf < 16'hFFFF) m_perf++;
      if (!h) begin
        m_a++;
        if (m_a == m_rows + P) begin m_busy = 0; nd = 1; end
      end
    end else if (!m_done && st) begin
      m_perf = 0;
      if (rows == 0) nd = 1;
      else begin
        m_busy = 1; m_a = 0; m_rows = int'(rows); m_ub = ub; m_acc = acc;
      end
    end
    m_done = nd;
  endtask

  task automatic check(string tag, out_t exp);
    out_t act;
    act = '{busy:sys_busy, done:sys_done, rd:ub_rd_en, arr:arr_en, wr:acc_wr_en,
            err:sys_err, rd_addr:ub_rd_addr, wr_addr:acc_wr_addr, perf:perf_cycles};
    // addresses only matter while their strobe is expected
    if (!exp.rd) begin act.rd_addr = '0; exp.rd_addr = '0; end
    if (!exp.wr) begin act.wr_addr = '0; exp.wr_addr = '0; end
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cycle %0d: got busy=%b done=%b rd=%b@%h arr=%b wr=%b@%h err=%b perf=%0d, want busy=%b done=%b rd=%b@%h arr=%b wr=%b@%h err=%b perf=%0d",
        tag, cyc, act.busy, act.done, act.rd, act.rd_addr, act.arr, act.wr, act.wr_addr, act.err, act.perf,
        exp.busy, exp.done, exp.rd, exp.rd_addr, exp.arr, exp.wr, exp.wr_addr, exp.err, exp.perf);
    end
  endtask

  // One clock: drive on negedge, compare 1 ns later, then step the model.
  task automatic cycle(string tag, logic rst, logic st, logic [7:0] rows,
                       logic [7:0] ub, logic [7:0] acc, logic h,
                       bit use_tbl, out_t tbl_exp);
    out_t exp;
    @(negedge clk);
    rst_n = rst; sys_start = st; sys_rows = rows; ub_base = ub; acc_base = acc; hold = h;
    #1;
    exp = use_tbl ? tbl_exp : model_out(h);
    check(tag, exp);
    model_step(rst, st, rows, ub, acc, h);
    cyc++;
  endtask

  task automatic run(string tag, logic rst, logic st, logic [7:0] rows,
                     logic [7:0] ub, logic [7:0] acc, logic h);
    cycle(tag, rst, st, rows, ub, acc, h, 1'b0, '0);
  endtask

  task automatic idle(string tag, int n);
    for (int i = 0; i < n; i++) run(tag, 1, 0, 0, 0, 0, 0);
  endtask

  function automatic vec_t mk(logic st, logic [7:0] rows, logic [7:0] ub, logic [7:0] acc,
                              logic h, logic busy, logic done, logic rd, logic [7:0] rda,
                              logic wr, logic [7:0] wra, int perf);
    vec_t v;
    v.start = st; v.rows = rows; v.ub = ub; v.acc = acc; v.hold = h;
    v.exp = '{busy:busy, done:done, rd:rd, arr:busy & ~h, wr:wr, err:1'b0,
              rd_addr:rda, wr_addr:wra, perf:perf_val(perf)};
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    // Basic 4x4: ub 0x00, acc 0x20, start at k=0; reads k=1..4, writes k=9..12,
    // done k=13, busy-cycle count 12.
    tbl[0] = mk(1, 4, 8'h00, 8'h20, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 14; k++)
      tbl[k] = mk(0, 0, 0, 0, 0, k <= 12, k == 13, k <= 4, 8'(k - 1),
                  k >= 9 && k <= 12, 8'(8'h20 + k - 9), (k <= 13) ? k - 1 : 12);

    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);

    idle("post_reset", 2);
    for (int i = 0; i < 15; i++)
      cycle("basic_tbl", 1, tbl[i].start, tbl[i].rows, tbl[i].ub, tbl[i].acc,
            tbl[i].hold, 1'b1, tbl[i].exp);

    // zero rows
    run("zero_rows", 1, 1, 0, 8'h10, 8'h30, 0);
    idle("zero_rows", 3);

    // hold in T+2 and T+10
    run("hold", 1, 1, 4, 8'h40, 8'h50, 0);
    for (int k = 1; k <= 17; k++) run("hold", 1, 0, 0, 0, 0, (k == 2 || k == 10));

    // wrap
    run("wrap", 1, 1, 3, 8'hFE, 8'hFF, 0);
    idle("wrap", P + 5);

    // reset mid-FEED, then a normal start
    run("rst_mid", 1, 1, 4, 8'h00, 8'h20, 0);
    run("rst_mid", 1, 0, 0, 0, 0, 0);
    run("rst_mid", 0, 0, 0, 0, 0, 0);
    idle("rst_mid", P + 6);
    run("rst_mid_restart", 1, 1, 4, 8'h08, 8'h28, 0);
    idle("rst_mid_restart", P + 6);

    // start while busy at T+5, then start in the done cycle
    run("busy_start", 1, 1, 4, 8'h60, 8'h70, 0);
    for (int k = 1; k <= 4; k++) run("busy_start", 1, 0, 0, 0, 0, 0);
    run("busy_start", 1, 1, 2, 8'h99, 8'h99, 0);
    for (int k = 6; k <= 12; k++) run("busy_start", 1, 0, 0, 0, 0, 0);
    run("done_start", 1, 1, 2, 8'h11, 8'h22, 0);
    idle("err_sticky", 4);
    run("err_clear", 0, 0, 0, 0, 0, 0);
    idle("err_clear", 2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, s, h;
      logic [7:0] rows;
      r    = ($urandom_range(0, 299) != 0);
      s    = ($urandom_range(0, 9) == 0);
      h    = ($urandom_range(0, 5) == 0);
      rows = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 14));
      run("random", r, s, rows, 8'($urandom), 8'($urandom), h);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
